// File: rtl/mem_cpu_port_arb_pkg.sv
// Shared types and helpers for the memory CPU-port arbiter.
package mem_arb_pkg;

  localparam int TO_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int k = 0; k < 32; k++) begin
      if (v > 0) begin
        r++;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_cpu_port_arb_if.sv
// Requester-side and controller-side signals of the CPU-port arbiter, plus status.
interface mem_cpu_port_arb_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) ();
  import mem_arb_pkg::*;

  localparam int GW = clog2(N_REQ);

  logic [N_REQ-1:0]            reqVld;
  logic [N_REQ-1:0]            reqRd;
  logic [N_REQ*ADDR_WIDTH-1:0] reqAddr;
  logic [N_REQ*DATA_WIDTH-1:0] reqWrData;
  logic [N_REQ-1:0]            reqAck;
  logic [N_REQ-1:0]            reqErr;
  logic [DATA_WIDTH-1:0]       reqRdData;
  logic                        cpuMemReq;
  logic                        cpuMemRd;
  logic [ADDR_WIDTH-1:0]       cpuMemAddr;
  logic [DATA_WIDTH-1:0]       cpuMemWrData;
  logic                        cpuMemAck;
  logic [DATA_WIDTH-1:0]       cpuMemRdData;
  logic                        busy;
  logic [GW-1:0]               grantIdx;
  logic                        errTimeout;

  modport slave (
    input  reqVld, reqRd, reqAddr, reqWrData, cpuMemAck, cpuMemRdData,
    output reqAck, reqErr, reqRdData, cpuMemReq, cpuMemRd, cpuMemAddr, cpuMemWrData,
           busy, grantIdx, errTimeout
  );

  modport master (
    output reqVld, reqRd, reqAddr, reqWrData, cpuMemAck, cpuMemRdData,
    input  reqAck, reqErr, reqRdData, cpuMemReq, cpuMemRd, cpuMemAddr, cpuMemWrData,
           busy, grantIdx, errTimeout
  );

endinterface

// File: rtl/mem_cpu_port_arb_rr_pick.sv
// Rotating-priority picker: first valid requester strictly after rr_ptr, wrapping.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [clog2(N_REQ)-1:0] rr_ptr,
  output logic                    any_vld,
  output logic [clog2(N_REQ)-1:0] winner
);
  localparam int GW = clog2(N_REQ);

  logic          found;
  logic [GW-1:0] idx;

  always_comb begin
    any_vld = |req_vld;
    winner  = rr_ptr;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = GW'((int'(rr_ptr) + i) % N_REQ);
      if (!found && req_vld[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_cpu_port_arb.sv
// Round-robin share of the memory controller CPU port with request gap and timeout abort.
// IDLE: arbitrate | ISSUE: request held until ack or timeout | GAP: forced request-low spacing
module mem_cpu_port_arb
  import mem_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clockCore,
  input  logic              resetCore,
  mem_cpu_port_arb_if.slave bus
);
  localparam int GW    = clog2(N_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;

  arb_state_e            state_q, state_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d, grant_q, grant_d;
  logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  mem_req_q, mem_req_d, mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d, rd_data_q, rd_data_d;
  logic [N_REQ-1:0]      ack_q, ack_d, err_q, err_d;
  logic                  busy_q, busy_d, err_to_q, err_to_d;

  logic                  any_vld;
  logic [GW-1:0]         winner;
  logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i]  = bus.reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = bus.reqWrData[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_vld (bus.reqVld),
    .rr_ptr  (rr_ptr_q),
    .any_vld (any_vld),
    .winner  (winner)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    mem_req_d   = mem_req_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    err_to_d    = err_to_q;
    ack_d       = '0;
    err_d       = '0;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          state_d     = ISSUE;
          grant_d     = winner;
          rr_ptr_d    = winner;
          to_cnt_d    = '0;
          mem_req_d   = 1'b1;
          mem_rd_d    = bus.reqRd[winner];
          mem_addr_d  = addr_arr[winner];
          mem_wdata_d = wdata_arr[winner];
        end
      end
      ISSUE: begin
        // Ack is checked first so a completion on the last allowed cycle is not reported as an error.
        if (bus.cpuMemAck) begin
          ack_d[grant_q] = 1'b1;
          rd_data_d      = bus.cpuMemRdData;
          mem_req_d      = 1'b0;
          gap_cnt_d      = '0;
          state_d        = GAP;
        end else if (to_cnt_q == TO_CNT_W'(TIMEOUT - 1)) begin
          err_d[grant_q] = 1'b1;
          err_to_d       = 1'b1;
          mem_req_d      = 1'b0;
          gap_cnt_d      = '0;
          state_d        = GAP;
        end else if (to_cnt_q != {TO_CNT_W{1'b1}}) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      state_q     <= IDLE;
      rr_ptr_q    <= GW'(N_REQ - 1);
      grant_q     <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      err_to_q    <= err_to_d;
    end
  end

  assign bus.reqAck       = ack_q;
  assign bus.reqErr       = err_q;
  assign bus.reqRdData    = rd_data_q;
  assign bus.cpuMemReq    = mem_req_q;
  assign bus.cpuMemRd     = mem_rd_q;
  assign bus.cpuMemAddr   = mem_addr_q;
  assign bus.cpuMemWrData = mem_wdata_q;
  assign bus.busy         = busy_q;
  assign bus.grantIdx     = grant_q;
  assign bus.errTimeout   = err_to_q;

endmodule

// File: tb/tb_mem_cpu_port_arb.sv
// Directed and randomized checks of mem_cpu_port_arb against a transaction-level reference model.
module tb_mem_cpu_port_arb;
  localparam int N    = 4;
  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int GAPC = 2;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_cpu_port_arb_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_cpu_port_arb #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GAP_CYCLES(GAPC), .TIMEOUT(TO)
  ) dut (
    .clockCore (clk),
    .resetCore (rst),
    .bus       (bus)
  );

  logic [AW-1:0] a_addr [N];
  logic [DW-1:0] a_wd   [N];
  logic [N-1:0]  a_rd;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.reqAddr[i*AW +: AW]   = a_addr[i];
      bus.reqWrData[i*DW +: DW] = a_wd[i];
    end
    bus.reqRd = a_rd;
  end

  int tests = 0;
  int fails = 0;

  // Reference model state: last granted requester, sticky timeout, last delivered read data.
  int          m_last  = N - 1;
  bit          m_err   = 1'b0;
  logic [15:0] m_rdata = '0;
  int          last_lows;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // One transaction: wait for grant, ack after lat request cycles (lat outside 1..TO: never ack).
  task automatic run_txn(input int lat, input logic [15:0] rdv, input bit drop_vld, output int g);
    int waits, high, exp_g, exp_high;
    bit acked;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic er;
    logic [N-1:0] oh;
    exp_g = rr_next(bus.reqVld, m_last);
    waits = 0;
    while (bus.cpuMemReq !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    last_lows = waits;
    chk("grant_wait", 32'(waits < 20), 32'd1);
    if (waits >= 20 || exp_g < 0) begin
      g = -1;
      return;
    end
    g = int'(bus.grantIdx);
    chk("grant_idx", 32'(bus.grantIdx), 32'(exp_g));
    chk("busy_issue", 32'(bus.busy), 32'd1);
    ea = a_addr[exp_g];
    ew = a_wd[exp_g];
    er = a_rd[exp_g];
    m_last = exp_g;
    oh = '0;
    oh[exp_g] = 1'b1;
    acked = (lat >= 1 && lat <= TO);
    exp_high = acked ? lat : TO;
    high = 0;
    while (bus.cpuMemReq === 1'b1 && high < TO + 4) begin
      high++;
      chk("hold_fields", 32'({bus.cpuMemRd, bus.cpuMemAddr, bus.cpuMemWrData}), 32'({er, ea, ew}));
      if (high == 1 && drop_vld) bus.reqVld[exp_g] = 1'b0;
      if (high == 2) a_addr[exp_g] = a_addr[exp_g] + 8'h10;
      if (high == lat) begin
        bus.cpuMemAck    = 1'b1;
        bus.cpuMemRdData = rdv;
      end
      @(negedge clk);
      bus.cpuMemAck    = 1'b0;
      bus.cpuMemRdData = 16'($urandom);
    end
    chk("req_high_cycles", 32'(high), 32'(exp_high));
    if (acked) m_rdata = rdv;
    else m_err = 1'b1;
    chk("ack_pulse", 32'(bus.reqAck), acked ? 32'(oh) : 32'd0);
    chk("err_pulse", 32'(bus.reqErr), acked ? 32'd0 : 32'(oh));
    chk("rd_data", 32'(bus.reqRdData), 32'(m_rdata));
    chk("err_timeout", 32'(bus.errTimeout), 32'(m_err));
    @(negedge clk);
    chk("pulse_clear", 32'({bus.reqAck, bus.reqErr}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_last  = N - 1;
    m_err   = 1'b0;
    m_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, lat, waits;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = 8'(i * 16);
      a_wd[i]   = 16'(16'h1000 + i);
    end
    a_rd = '0;
    bus.reqVld       = '0;
    bus.cpuMemAck    = 1'b0;
    bus.cpuMemRdData = '0;

    // Reset values, observed while reset is held.
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.cpuMemReq), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant", 32'(bus.grantIdx), 32'd0);
    chk("rst_outs", 32'({bus.reqAck, bus.reqErr, bus.errTimeout, bus.cpuMemRd}), 32'd0);
    chk("rst_data", 32'({bus.reqRdData, bus.cpuMemAddr}), 32'd0);
    rst = 1'b0;

    // No requests: stay idle.
    repeat (4) @(negedge clk);
    chk("idle_req", 32'(bus.cpuMemReq), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Single read from requester 1.
    a_addr[1] = 8'h3C;
    a_rd[1]   = 1'b1;
    bus.reqVld = 4'b0010;
    run_txn(5, 16'hBEEF, 1'b0, g);
    chk("single_grant", 32'(g), 32'd1);
    chk("single_data", 32'(bus.reqRdData), 32'hBEEF);
    bus.reqVld = '0;

    // Round robin from reset with everyone valid. Between grants the request is low for the
    // GAP cycles plus the IDLE arbitration cycle; the first low cycle is seen inside run_txn.
    do_reset();
    bus.reqVld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_txn(3, 16'($urandom), 1'b0, g);
      chk("rr_order", 32'(g), 32'(k % N));
      if (k > 0) chk("gap_low", 32'(1 + last_lows), 32'(GAPC + 1));
    end
    bus.reqVld = '0;

    // Field stability: requester 0 moves 0x10 -> 0x20 mid-request (done inside run_txn).
    a_addr[0] = 8'h10;
    bus.reqVld = 4'b0001;
    run_txn(4, 16'h1234, 1'b0, g);
    chk("stable_addr_moved", 32'(a_addr[0]), 32'h20);
    bus.reqVld = '0;

    // Ack on the very cycle the timeout would fire: ack wins.
    bus.reqVld = 4'b0100;
    run_txn(TO, 16'hA5A5, 1'b0, g);
    chk("ack_at_to_err", 32'(bus.errTimeout), 32'd0);
    bus.reqVld = '0;

    // Timeout, then stray acks in GAP and IDLE.
    bus.reqVld = 4'b1000;
    run_txn(0, 16'h0, 1'b0, g);
    bus.reqVld = '0;
    bus.cpuMemAck = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.cpuMemAck = 1'b0;
    @(negedge clk);
    chk("stray_ack", 32'({bus.reqAck, bus.reqErr}), 32'd0);
    chk("stray_req", 32'(bus.cpuMemReq), 32'd0);
    chk("sticky_err", 32'(bus.errTimeout), 32'd1);

    // Randomized traffic, including requesters dropping reqVld while granted.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        a_addr[i] = 8'($urandom);
        a_wd[i]   = 16'($urandom);
      end
      a_rd       = 4'($urandom);
      bus.reqVld = 4'($urandom_range(1, 15));
      lat        = $urandom_range(1, TO + 1);
      run_txn(lat, 16'($urandom), 1'($urandom_range(0, 1)), g);
    end
    bus.reqVld = '0;

    // Reset in the middle of a request.
    @(negedge clk);
    bus.reqVld = 4'b0010;
    waits = 0;
    while (bus.cpuMemReq !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("mid_rst_grant_wait", 32'(waits < 20), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus.cpuMemReq), 32'd0);
    chk("mid_rst_outs", 32'({bus.busy, bus.grantIdx, bus.errTimeout, bus.reqAck, bus.reqErr}), 32'd0);
    chk("mid_rst_data", 32'(bus.reqRdData), 32'd0);
    m_last  = N - 1;
    m_err   = 1'b0;
    m_rdata = '0;
    @(negedge clk);
    chk("mid_rst_no_pulse", 32'({bus.reqAck, bus.reqErr}), 32'd0);
    rst = 1'b0;
    bus.reqVld = 4'b0101;
    run_txn(2, 16'h5A5A, 1'b0, g);
    chk("post_rst_winner", 32'(g), 32'd0);
    bus.reqVld = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
